// File: rtl/id_decode_pipe.sv
// Instruction-decode stage: fetch handshake, two-word immediate assembly, register
// file with write-through bypass, load-use stall and the ID/EX pipeline register.
module id_decode_pipe #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned REG_AW  = 3,
    parameter int unsigned PC_W    = 32,
    parameter logic [4:0]  IMM_OP  = 5'b10100,
    parameter logic [4:0]  LOAD_OP = 5'b10110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [4:0]        ex_opcode,
    output logic [WIDTH-1:0]  ex_op1,
    output logic [WIDTH-1:0]  ex_op2,
    output logic [WIDTH-1:0]  ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic [PC_W-1:0]   ex_pc,
    output logic              ex_is_load,
    output logic              hazard
);

    localparam int unsigned OP_W   = 5;
    localparam int unsigned NREG   = 2**REG_AW;
    localparam int unsigned RS1_HI = WIDTH - 6;
    localparam int unsigned RS2_HI = WIDTH - 6 - REG_AW;

    typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   lat_op_q, lat_op_d;
    logic [REG_AW-1:0] lat_rs1_q, lat_rs1_d;
    logic [REG_AW-1:0] lat_rs2_q, lat_rs2_d;
    logic [PC_W-1:0]   lat_pc_q, lat_pc_d;
    logic [WIDTH-1:0]  rf_q [NREG];
    logic [WIDTH-1:0]  rf_d [NREG];

    logic              ex_valid_q, ex_valid_d;
    logic [OP_W-1:0]   ex_opcode_q, ex_opcode_d;
    logic [WIDTH-1:0]  ex_op1_q, ex_op1_d;
    logic [WIDTH-1:0]  ex_op2_q, ex_op2_d;
    logic [WIDTH-1:0]  ex_imm_q, ex_imm_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
    logic              ex_is_load_q, ex_is_load_d;

    logic [OP_W-1:0]   in_op_c, cur_op_c;
    logic [REG_AW-1:0] cur_rs1_c, cur_rs2_c;
    logic [PC_W-1:0]   cur_pc_c;
    logic [WIDTH-1:0]  cur_imm_c, op1_c, op2_c;
    logic              is_imm_op_c, complete_c, adv_c, hazard_c, in_ready_c;

    // Current instruction view: live word in S_OP, latched opcode fields in S_IMM.
    always_comb begin
        in_op_c     = in_instr[WIDTH-1 -: OP_W];
        is_imm_op_c = (state_q == S_OP) && (in_op_c == IMM_OP);
        complete_c  = in_valid && !is_imm_op_c;
        if (state_q == S_IMM) begin
            cur_op_c  = lat_op_q;
            cur_rs1_c = lat_rs1_q;
            cur_rs2_c = lat_rs2_q;
            cur_pc_c  = lat_pc_q;
            cur_imm_c = in_instr;
        end else begin
            cur_op_c  = in_op_c;
            cur_rs1_c = in_instr[RS1_HI -: REG_AW];
            cur_rs2_c = in_instr[RS2_HI -: REG_AW];
            cur_pc_c  = in_pc;
            cur_imm_c = '0;
        end
        op1_c = (wb_en && (wb_addr == cur_rs1_c)) ? wb_data : rf_q[cur_rs1_c];
        op2_c = (wb_en && (wb_addr == cur_rs2_c)) ? wb_data : rf_q[cur_rs2_c];
        adv_c = !ex_valid_q || ex_ready;
        hazard_c = ex_valid_q && ex_is_load_q && complete_c &&
                   ((ex_rd_q == cur_rs1_c) || (ex_rd_q == cur_rs2_c));
        // An opcode-only word never touches ID/EX, so it need not wait for EX.
        in_ready_c = !hazard_c && !flush && (is_imm_op_c || adv_c);
    end

    always_comb begin
        state_d      = state_q;
        lat_op_d     = lat_op_q;
        lat_rs1_d    = lat_rs1_q;
        lat_rs2_d    = lat_rs2_q;
        lat_pc_d     = lat_pc_q;
        rf_d         = rf_q;
        ex_valid_d   = ex_valid_q;
        ex_opcode_d  = ex_opcode_q;
        ex_op1_d     = ex_op1_q;
        ex_op2_d     = ex_op2_q;
        ex_imm_d     = ex_imm_q;
        ex_rd_d      = ex_rd_q;
        ex_pc_d      = ex_pc_q;
        ex_is_load_d = ex_is_load_q;

        if (wb_en) begin
            rf_d[wb_addr] = wb_data;
        end

        if (flush) begin
            state_d    = S_OP;
            ex_valid_d = 1'b0;
        end else begin
            if (in_valid && in_ready_c) begin
                if (is_imm_op_c) begin
                    state_d   = S_IMM;
                    lat_op_d  = cur_op_c;
                    lat_rs1_d = cur_rs1_c;
                    lat_rs2_d = cur_rs2_c;
                    lat_pc_d  = cur_pc_c;
                end else begin
                    state_d = S_OP;
                end
            end
            if (complete_c && in_ready_c) begin
                ex_valid_d   = 1'b1;
                ex_opcode_d  = cur_op_c;
                ex_op1_d     = op1_c;
                ex_op2_d     = op2_c;
                ex_imm_d     = cur_imm_c;
                ex_rd_d      = cur_rs2_c;
                ex_pc_d      = cur_pc_c;
                ex_is_load_d = (cur_op_c == LOAD_OP);
            end else if (adv_c) begin
                ex_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_OP;
            lat_op_q     <= '0;
            lat_rs1_q    <= '0;
            lat_rs2_q    <= '0;
            lat_pc_q     <= '0;
            rf_q         <= '{default: '0};
            ex_valid_q   <= 1'b0;
            ex_opcode_q  <= '0;
            ex_op1_q     <= '0;
            ex_op2_q     <= '0;
            ex_imm_q     <= '0;
            ex_rd_q      <= '0;
            ex_pc_q      <= '0;
            ex_is_load_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_op_q     <= lat_op_d;
            lat_rs1_q    <= lat_rs1_d;
            lat_rs2_q    <= lat_rs2_d;
            lat_pc_q     <= lat_pc_d;
            rf_q         <= rf_d;
            ex_valid_q   <= ex_valid_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_op1_q     <= ex_op1_d;
            ex_op2_q     <= ex_op2_d;
            ex_imm_q     <= ex_imm_d;
            ex_rd_q      <= ex_rd_d;
            ex_pc_q      <= ex_pc_d;
            ex_is_load_q <= ex_is_load_d;
        end
    end

    assign in_ready   = in_ready_c;
    assign hazard     = hazard_c;
    assign ex_valid   = ex_valid_q;
    assign ex_opcode  = ex_opcode_q;
    assign ex_op1     = ex_op1_q;
    assign ex_op2     = ex_op2_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rd      = ex_rd_q;
    assign ex_pc      = ex_pc_q;
    assign ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_id_decode_pipe.sv
// Bench for id_decode_pipe: transaction-level decode model checked every cycle,
// plus directed scenarios with hand-computed expected outputs.
module tb_id_decode_pipe;

    localparam logic [4:0] IMM_OP  = 5'b10100;
    localparam logic [4:0] LOAD_OP = 5'b10110;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'h0;
    logic [31:0] in_pc = 32'h0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = 3'd0;
    logic [15:0] wb_data = 16'h0;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [4:0]  ex_opcode;
    logic [15:0] ex_op1, ex_op2, ex_imm;
    logic [2:0]  ex_rd;
    logic [31:0] ex_pc;
    logic        ex_is_load;
    logic        hazard;

    int checks = 0;
    int errs   = 0;
    int acc_cnt = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic [2:0]  rd;
        logic [31:0] pc;
        logic        ld;
    } ex_t;

    id_decode_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_pc(ex_pc), .ex_is_load(ex_is_load), .hazard(hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b);
        return {op, a, b, 5'b00000};
    endfunction

    // Model state: register file, pending opcode word, ID/EX contents.
    logic [15:0] m_rf [8];
    bit          m_pend;
    logic [4:0]  m_lop;
    logic [2:0]  m_lrs1, m_lrs2;
    logic [31:0] m_lpc;
    bit          m_exv;
    ex_t         m_ex;

    function automatic logic [15:0] rf_rd(input logic [2:0] a);
        return (wb_en && wb_addr == a) ? wb_data : m_rf[a];
    endfunction

    always @(negedge clk) begin : model_chk
        logic [4:0]  c_op;
        logic [2:0]  c_rs1, c_rs2;
        logic [31:0] c_pc;
        logic [15:0] c_imm;
        bit          first_imm, done, e_haz, e_rdy;
        ex_t         nx, dut_ex;
        if (!rst) begin
            m_pend = 0;
            m_exv  = 0;
            m_ex   = '0;
            for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
            chk("rst_ex_valid", 128'(ex_valid), 128'(0));
            chk("rst_hazard", 128'(hazard), 128'(0));
        end else begin
            first_imm = !m_pend && (in_instr[15:11] == IMM_OP);
            done      = in_valid && !first_imm;
            if (m_pend) begin
                c_op = m_lop; c_rs1 = m_lrs1; c_rs2 = m_lrs2; c_pc = m_lpc; c_imm = in_instr;
            end else begin
                c_op = in_instr[15:11]; c_rs1 = in_instr[10:8]; c_rs2 = in_instr[7:5];
                c_pc = in_pc; c_imm = 16'h0;
            end
            e_haz = m_exv && m_ex.ld && (m_ex.rd == c_rs1 || m_ex.rd == c_rs2) && done;
            e_rdy = !flush && !e_haz && (first_imm || !m_exv || ex_ready);

            chk("mdl_ex_valid", 128'(ex_valid), 128'(m_exv));
            chk("mdl_in_ready", 128'(in_ready), 128'(e_rdy));
            chk("mdl_hazard", 128'(hazard), 128'(e_haz));
            dut_ex = '{op: ex_opcode, op1: ex_op1, op2: ex_op2, imm: ex_imm,
                       rd: ex_rd, pc: ex_pc, ld: ex_is_load};
            if (m_exv) chk("mdl_ex_fields", 128'(dut_ex), 128'(m_ex));

            nx = '{op: c_op, op1: rf_rd(c_rs1), op2: rf_rd(c_rs2), imm: c_imm,
                   rd: c_rs2, pc: c_pc, ld: (c_op == LOAD_OP)};
            if (flush) begin
                m_pend = 0;
                m_exv  = 0;
            end else begin
                if (in_valid && e_rdy) begin
                    if (first_imm) begin
                        m_pend = 1; m_lop = c_op; m_lrs1 = c_rs1; m_lrs2 = c_rs2; m_lpc = c_pc;
                    end else begin
                        m_pend = 0;
                    end
                end
                if (done && e_rdy) begin
                    m_exv = 1;
                    m_ex  = nx;
                end else if (ex_ready) begin
                    m_exv = 0;
                end
            end
            if (wb_en) m_rf[wb_addr] = wb_data;
        end
    end

    task automatic step(input logic v, input logic [15:0] ins, input logic [31:0] pc,
                        input logic fl, input logic er, input logic we,
                        input logic [2:0] wa, input logic [15:0] wd);
        @(posedge clk);
        #1;
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; ex_ready = er;
        wb_en = we; wb_addr = wa; wb_data = wd;
        @(negedge clk);
        if (in_valid && in_ready) acc_cnt++;
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_ex_valid", 128'(ex_valid), 128'(0));

        // Writeback bypass into a same-cycle operand read
        step(1'b1, enc(5'b00001, 3'd3, 3'd0), 32'h10, 1'b0, 1'b1, 1'b1, 3'd3, 16'hBEEF);
        chk("byp_in_ready", 128'(in_ready), 128'(1));
        idle();
        chk("byp_ex_valid", 128'(ex_valid), 128'(1));
        chk("byp_ex_op1", 128'(ex_op1), 128'(16'hBEEF));
        chk("byp_ex_pc", 128'(ex_pc), 128'(32'h10));

        // Two-word immediate instruction
        step(1'b1, 16'hA000, 32'h40, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        chk("imm_op_ready", 128'(in_ready), 128'(1));
        step(1'b1, 16'h1234, 32'h42, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        chk("imm_wait_valid", 128'(ex_valid), 128'(0));
        idle();
        chk("imm_ex_valid", 128'(ex_valid), 128'(1));
        chk("imm_ex_imm", 128'(ex_imm), 128'(16'h1234));
        chk("imm_ex_pc", 128'(ex_pc), 128'(32'h40));
        chk("imm_ex_opcode", 128'(ex_opcode), 128'(5'b10100));
        idle();
        chk("imm_one_pulse", 128'(ex_valid), 128'(0));

        // Load-use stall: load rd=2 then consumer with rs1=2
        step(1'b1, enc(LOAD_OP, 3'd0, 3'd2), 32'h50, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        step(1'b1, enc(5'b00001, 3'd2, 3'd1), 32'h52, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        chk("lu_hazard", 128'(hazard), 128'(1));
        chk("lu_in_ready", 128'(in_ready), 128'(0));
        chk("lu_is_load", 128'(ex_is_load), 128'(1));
        step(1'b1, enc(5'b00001, 3'd2, 3'd1), 32'h52, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        chk("lu_bubble", 128'(ex_valid), 128'(0));
        chk("lu_hazard_clr", 128'(hazard), 128'(0));
        chk("lu_ready_again", 128'(in_ready), 128'(1));
        idle();
        chk("lu_issue_valid", 128'(ex_valid), 128'(1));
        chk("lu_issue_pc", 128'(ex_pc), 128'(32'h52));

        // EX backpressure for three cycles
        acc0 = acc_cnt;
        step(1'b1, enc(5'b00011, 3'd1, 3'd2), 32'h60, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, enc(5'b00100, 3'd4, 3'd5), 32'h62, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
            chk("bp_hold_valid", 128'(ex_valid), 128'(1));
            chk("bp_hold_pc", 128'(ex_pc), 128'(32'h60));
            chk("bp_hold_op", 128'(ex_opcode), 128'(5'b00011));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        step(1'b1, enc(5'b00100, 3'd4, 3'd5), 32'h62, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        chk("bp_resume_ready", 128'(in_ready), 128'(1));
        idle();
        chk("bp_next_pc", 128'(ex_pc), 128'(32'h62));
        chk("bp_next_op", 128'(ex_opcode), 128'(5'b00100));
        idle();
        chk("bp_no_dup", 128'(ex_valid), 128'(0));
        chk("bp_accept_cnt", 128'(acc_cnt - acc0), 128'(2));

        // Flush in S_IMM while ID/EX holds an instruction; writeback still lands
        step(1'b1, enc(5'b00001, 3'd0, 3'd0), 32'h70, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        step(1'b1, 16'hA000, 32'h72, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("fl_imm_ready_stalled_ex", 128'(in_ready), 128'(1));
        step(1'b1, 16'hBBBB, 32'h74, 1'b1, 1'b0, 1'b1, 3'd1, 16'h5A5A);
        chk("fl_in_ready", 128'(in_ready), 128'(0));
        chk("fl_ex_valid_before", 128'(ex_valid), 128'(1));
        step(1'b1, 16'h1234, 32'h76, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        chk("fl_ex_valid_after", 128'(ex_valid), 128'(0));
        chk("fl_ready_after", 128'(in_ready), 128'(1));
        idle();
        chk("fl_op_valid", 128'(ex_valid), 128'(1));
        chk("fl_op_opcode", 128'(ex_opcode), 128'(5'b00010));
        chk("fl_op_imm", 128'(ex_imm), 128'(0));
        chk("fl_op_rd", 128'(ex_rd), 128'(3'd1));
        chk("fl_op_op2_wb", 128'(ex_op2), 128'(16'h5A5A));

        // Asynchronous reset while in S_IMM
        step(1'b1, 16'hA000, 32'h80, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_instr = 16'h0; in_pc = 32'h0;
        @(negedge clk);
        chk("ar_ex_valid", 128'(ex_valid), 128'(0));
        chk("ar_ex_fields", 128'({ex_opcode, ex_op1, ex_op2, ex_imm, ex_rd, ex_pc, ex_is_load}), 128'(0));
        chk("ar_hazard", 128'(hazard), 128'(0));
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("ar_in_ready", 128'(in_ready), 128'(1));
        step(1'b1, enc(5'b00001, 3'd3, 3'd0), 32'h90, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        idle();
        chk("ar_next_valid", 128'(ex_valid), 128'(1));
        chk("ar_next_opcode", 128'(ex_opcode), 128'(5'b00001));
        chk("ar_next_imm", 128'(ex_imm), 128'(0));
        chk("ar_next_pc", 128'(ex_pc), 128'(32'h90));
        chk("ar_rf_cleared", 128'(ex_op1), 128'(0));
        idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/id_decode_pipe.md
Name: id_decode_pipe

Overview:
Parameterised instruction-decode stage for the RISC pipeline. It accepts instruction words from fetch through a valid/ready handshake. Two-word immediate instructions (LDM-class) are assembled by a small FSM. The block reads an internal register file with write-through bypass, detects load-use hazards and inserts bubbles, and holds the ID/EX pipeline register with its own valid/ready handshake toward execute. It sits between the fetch stage and the ALU/EX stage.

Parameters:
WIDTH, 16, instruction word, immediate and register data width
REG_AW, 3, register address width; register count is 2**REG_AW; constraint WIDTH >= 5+2*REG_AW
PC_W, 32, program counter width
IMM_OP, 5'b10100, opcode of two-word (immediate-follows) instructions
LOAD_OP, 5'b10110, opcode of memory-load instructions (load-use hazard source)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  fetch presents in_instr/in_pc
in_ready  out  1  decode accepts the word this cycle
in_instr  in  WIDTH  instruction or immediate word
in_pc  in  PC_W  PC of in_instr
flush  in  1  branch taken/interrupt: squash everything in decode
wb_en  in  1  register-file write enable from writeback
wb_addr  in  REG_AW  writeback register
wb_data  in  WIDTH  writeback data
ex_valid  out  1  ID/EX register holds an instruction
ex_ready  in  1  EX consumes the ID/EX register this cycle
ex_opcode  out  5  decoded opcode
ex_op1  out  WIDTH  rs1 value
ex_op2  out  WIDTH  rs2/rdst value
ex_imm  out  WIDTH  immediate word (0 for single-word instructions)
ex_rd  out  REG_AW  destination register
ex_pc  out  PC_W  PC of the opcode word
ex_is_load  out  1  opcode == LOAD_OP
hazard  out  1  load-use stall asserted this cycle

Behaviour:
- Field layout: opcode = instr[WIDTH-1 -: 5]; rs1 = instr[WIDTH-6 -: REG_AW]; rs2 and rd = instr[WIDTH-6-REG_AW -: REG_AW].
- Register file: 2**REG_AW x WIDTH, two combinational read ports, one write port on posedge clk when wb_en. A same-cycle read of wb_addr returns wb_data (bypass). Reset clears all entries to 0.
- FSM states:
  - S_OP (reset): expects an opcode word.
  - S_IMM: expects the immediate word.
- S_OP, word accepted with opcode == IMM_OP:
  - latch opcode, rs1, rs2/rd and pc; go to S_IMM.
  - The ID/EX register is not loaded.
- S_OP, word accepted with any other opcode: the instruction completes this cycle.
- S_IMM, word accepted: the instruction completes with imm = in_instr; return to S_OP.
- cur_rs1/cur_rs2: taken from in_instr in S_OP and from the latched fields in S_IMM. Operands are read at the completion cycle, so writebacks that occur between the two words are visible.
- adv = !ex_valid || ex_ready.
- hazard = ex_valid && ex_is_load && (ex_rd == cur_rs1 || ex_rd == cur_rs2) && (in_valid completes an instruction this cycle). It is combinational.
- in_ready = adv && !hazard && !flush, except that an accepted S_OP word with opcode == IMM_OP requires only !hazard && !flush.
- ID/EX update on posedge:
  - completion && in_ready: load all ex_* fields, ex_valid <= 1.
  - else if adv: ex_valid <= 0 (bubble). A hazard produces exactly one bubble, because ex_valid is 0 the next cycle.
  - else: hold all ex_* fields unchanged (backpressure).
- flush (highest priority, synchronous):
  - ex_valid <= 0, FSM -> S_OP, latched partial instruction discarded, in_ready = 0 that cycle.
  - Register-file writes still occur.
- Reset (asynchronous, mid-operation included): FSM S_OP, ex_valid 0, every ex_* output 0, hazard 0, register file all 0. in_ready is 1 after reset release.
- Latency: single-word instruction accepted at cycle N -> ex_valid at N+1. Two-word: immediate word accepted at N -> ex_valid at N+1.
- Throughput: one instruction per cycle while ex_ready = 1.

Test Plan:
1. Reset mid-S_IMM (opcode IMM_OP accepted, rst low for 1 cycle) -> ex_valid 0, all ex_* 0, FSM S_OP; the next word is decoded as an opcode.
2. wb_en = 1, wb_addr = 3, wb_data = 16'hBEEF, same cycle as a single-word instruction with rs1 = 3 -> next cycle ex_op1 = 16'hBEEF, ex_valid 1.
3. Words 16'hA000 (IMM_OP), then 16'h1234 at pc 0x40 -> one ex_valid pulse with ex_imm = 16'h1234, ex_pc = 0x40, ex_opcode = 5'b10100.
4. LOAD_OP with rd = 2 in ID/EX, next word reads rs1 = 2 -> hazard = 1 and in_ready = 0 for one cycle, then one bubble (ex_valid 0), then the instruction issues.
5. ex_ready = 0 for 3 cycles while in_valid = 1 -> all ex_* held stable, in_ready = 0, no instruction lost or duplicated.
6. flush during S_IMM and with ex_valid = 1 -> ex_valid 0 the next cycle, FSM S_OP; the following 16'h1234 is treated as an opcode word.
